seg7_number_decoder: RTL
========================

# seg7_number_decoder

Sequential decoder that converts a bank of `DIGITS` seven-segment display codes into a binary number. It sits between the keypad/display front end and the IC-lookup logic. On a `start` request it snapshots all segment codes and accumulates them most-significant digit first, one digit per clock (`acc = acc*10 + d`). It then reports the number with validity, per-digit error and overflow status, handshaked by `busy`/`done`.

## Interface
Parameters:
- `DIGITS`, default 4: number of seven-segment digits; must be ≥ 1.
- `OUT_W`, default 32: width of `number`; must be ≥ 4.
- `SEG_ACTIVE_LOW`, default 1: 1 means a lit segment is 0; 0 means a lit segment is 1.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: conversion request; sampled only in IDLE.
- `seg_in`  in  7*DIGITS: segment codes; digit i (i=0 is units) at `[7i+6:7i]`; bit order gfedcba (bit 6 = g).
- `busy`  out  1: conversion in progress.
- `done`  out  1: one-cycle pulse; result outputs updated this cycle.
- `number`  out  OUT_W: decoded value, held until the next `done`.
- `valid`  out  1: every digit decoded legally and no overflow occurred.
- `err_digit`  out  DIGITS: bit i set means digit i was an illegal code.
- `overflow`  out  1: result exceeded 2^OUT_W−1.

## Operation
- Segment codes are normalised to active-low form: XOR with 7'h7F when `SEG_ACTIVE_LOW`=0.
- Legal active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
- Any other code decodes to 0 and sets its `err_digit` bit (the blank-code exception is under Configuration).
- FSM states: IDLE and ACC.
  - IDLE: when `start`=1, register `seg_in` into a snapshot, clear `acc`, the error accumulator and the overflow accumulator, set `idx`=DIGITS−1, go to ACC.
  - ACC: decode digit `idx`. Compute `acc*10 + d` at OUT_W+4 bits. Any nonzero bit above OUT_W−1 sets the sticky overflow accumulator. `acc` keeps the low OUT_W bits, i.e. wraps modulo 2^OUT_W.
  - ACC, `idx`=0: load `number`, `err_digit`, `overflow` and `valid` (= no error bits and no overflow); pulse `done`; return to IDLE. Otherwise decrement `idx`.
- `start` while `busy` is ignored; it is neither queued nor does it restart the conversion.
- Changes on `seg_in` after the snapshot do not affect the result in progress.
- Reset asserted mid-conversion aborts it: no `done`, and outputs return to reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `number`=0, `valid`=0, `err_digit`=0, `overflow`=0; FSM in IDLE.
- `start` sampled high at edge k:
  - `busy`=1 from after edge k through edge k+DIGITS.
  - `done`=1 and results valid for exactly the cycle after edge k+DIGITS.
  - Latency is DIGITS+1 edges from the `start` edge to the `done` cycle.
- During the `done` cycle the FSM is already in IDLE and `busy`=0. A `start` there is accepted, so back-to-back conversions cost DIGITS+1 cycles each.
- `number`, `valid`, `err_digit` and `overflow` change only at the edge that raises `done`.
- DIGITS=1: `busy` is high for one cycle, and `done` follows at edge k+1.

## Configuration
- `SEG_BLANK_AS_ZERO_EN`
  - Defined: the blank code (all segments off, active-low 1111111) decodes to 0 with no error. This allows unlit leading digits.
  - Undefined: blank is an illegal code; it sets its `err_digit` bit and forces `valid`=0.

## Test plan
- DIGITS=4, OUT_W=32, codes "7","4","0","8" (digit 3→0) → `number`=7408, `valid`=1, `err_digit`=0, `overflow`=0, `done` exactly 5 cycles after the `start` edge, `busy` high for 4 cycles.
- Digit 1 = 7'b1010101 (illegal), others "1","2","3" at digits 3, 2, 0 → `number`=1203, `err_digit`=4'b0010, `valid`=0.
- Digit 3 blank, others "3","2","1" → with `SEG_BLANK_AS_ZERO_EN`: 321 and `valid`=1. Without it: 321, `err_digit`=4'b1000, `valid`=0.
- DIGITS=4, OUT_W=8, digits "9","9","9","9" → `overflow`=1, `valid`=0, `number`=9999 mod 256 = 15.
- `start` held high continuously with codes "0","0","4","2" → a `done` pulse every 5 cycles, each with `number`=42. `start` pulsed while `busy` → no extra `done`.
- `rst_n` pulled low 2 cycles after `start` → `busy`/`done`/`number` go to 0 immediately, with no `done` pulse. After release, a new `start` converts normally.

Source files
------------

// File: rtl/seg7_number_decoder.sv
// seg7_number_decoder
// Converts a bank of DIGITS seven-segment codes into a binary number,
// most-significant digit first, one digit per clock (acc = acc*10 + d).
// Optional feature macro: SEG_BLANK_AS_ZERO_EN
//   defined   -> blank code (active-low 7'h7F) decodes to 0 with no error
//   undefined -> blank code is illegal and flags its err_digit bit
module seg7_number_decoder #(
  parameter int DIGITS         = 4,
  parameter int OUT_W          = 32,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7*DIGITS-1:0]   seg_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      number,
  output logic                  valid,
  output logic [DIGITS-1:0]     err_digit,
  output logic                  overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Decode one active-low segment code: returns {illegal, value[3:0]}.
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    logic [4:0] res;
    case (code)
      7'b1000000: res = {1'b0, 4'd0};
      7'b1111001: res = {1'b0, 4'd1};
      7'b0100100: res = {1'b0, 4'd2};
      7'b0110000: res = {1'b0, 4'd3};
      7'b0011001: res = {1'b0, 4'd4};
      7'b0010010: res = {1'b0, 4'd5};
      7'b0000010: res = {1'b0, 4'd6};
      7'b1111000: res = {1'b0, 4'd7};
      7'b0000000: res = {1'b0, 4'd8};
      7'b0011000: res = {1'b0, 4'd9};
`ifdef SEG_BLANK_AS_ZERO_EN
      7'b1111111: res = {1'b0, 4'd0};
`else
      7'b1111111: res = {1'b1, 4'd0};
`endif
      default:    res = {1'b1, 4'd0};
    endcase
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [7*DIGITS-1:0]   snap_q, snap_d;
  logic [OUT_W-1:0]      acc_q, acc_d;
  logic [DIGITS-1:0]     err_acc_q, err_acc_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [OUT_W-1:0]      number_q, number_d;
  logic                  valid_q, valid_d;
  logic [DIGITS-1:0]     err_digit_q, err_digit_d;
  logic                  overflow_q, overflow_d;

  logic [6:0]            digit_arr_s [DIGITS];
  logic [6:0]            code_raw_s;
  logic [6:0]            code_norm_s;
  logic [4:0]            dec_s;
  logic [OUT_W+3:0]      acc_ext_s;
  logic [OUT_W+3:0]      prod_s;
  logic                  step_ovf_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digits
    assign digit_arr_s[g] = snap_q[7*g +: 7];
  end

  // Current digit: select from the snapshot, normalise polarity, decode, scale-and-add.
  always_comb begin
    code_raw_s  = digit_arr_s[idx_q];
    code_norm_s = SEG_ACTIVE_LOW ? code_raw_s : (code_raw_s ^ 7'h7F);
    dec_s       = seg_decode(code_norm_s);
    acc_ext_s   = {4'b0000, acc_q};
    prod_s      = (acc_ext_s << 3) + (acc_ext_s << 1) + {{OUT_W{1'b0}}, dec_s[3:0]};
    step_ovf_s  = |prod_s[OUT_W+3:OUT_W];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (idx_q == IDX_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values.
  always_comb begin
    snap_d      = snap_q;
    acc_d       = acc_q;
    err_acc_d   = err_acc_q;
    ovf_acc_d   = ovf_acc_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    number_d    = number_q;
    valid_d     = valid_q;
    err_digit_d = err_digit_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d    = seg_in;
          acc_d     = {OUT_W{1'b0}};
          err_acc_d = {DIGITS{1'b0}};
          ovf_acc_d = 1'b0;
          idx_d     = IDX_LAST;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      ST_ACC: begin
        acc_d            = prod_s[OUT_W-1:0];
        err_acc_d[idx_q] = dec_s[4];
        ovf_acc_d        = ovf_acc_q | step_ovf_s;
        if (idx_q == IDX_ZERO) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          number_d    = prod_s[OUT_W-1:0];
          err_digit_d = err_acc_d;
          overflow_d  = ovf_acc_d;
          valid_d     = ~(|err_acc_d) & ~ovf_acc_d;
        end else begin
          idx_d       = idx_q - IDX_ONE;
          busy_d      = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q      <= {(7*DIGITS){1'b0}};
      acc_q       <= {OUT_W{1'b0}};
      err_acc_q   <= {DIGITS{1'b0}};
      ovf_acc_q   <= 1'b0;
      idx_q       <= IDX_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      number_q    <= {OUT_W{1'b0}};
      valid_q     <= 1'b0;
      err_digit_q <= {DIGITS{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      acc_q       <= acc_d;
      err_acc_q   <= err_acc_d;
      ovf_acc_q   <= ovf_acc_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      number_q    <= number_d;
      valid_q     <= valid_d;
      err_digit_q <= err_digit_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign number    = number_q;
  assign valid     = valid_q;
  assign err_digit = err_digit_q;
  assign overflow  = overflow_q;

endmodule
